// File: rtl/gfx_wbm_readwrite.sv
// gfx_wbm_readwrite: single-word Wishbone B3 classic master for the GFX read/write arbiter.
// Optional bus timeout enabled by defining GFX_WBM_TIMEOUT_EN.
module gfx_wbm_readwrite #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        read_request_i,
  input  logic        write_request_i,
  input  logic [31:2] addr_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        busy_o,
  output logic        err_o,
  input  logic        err_clr_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);
  typedef enum logic [1:0] {IDLE, BUS, ACK} state_t;
  state_t state, state_nx;
  logic req, wr, tmo, fail, done;
  assign req = read_request_i | write_request_i;
  assign wr = write_request_i & we_i;
`ifdef GFX_WBM_TIMEOUT_EN
  logic [15:0] cnt;
  assign tmo = (state == BUS) && (cnt == 16'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) cnt <= '0;
    else cnt <= (state == BUS) ? cnt + 16'd1 : '0;
`else
  assign tmo = 1'b0;
`endif
  // err has priority over ack; an ack coinciding with timeout is a normal completion
  assign fail = wbm_err_i | (tmo & ~wbm_ack_i);
  assign done = wbm_ack_i | fail;
  assign wbm_cyc_o = (state == BUS);
  assign wbm_stb_o = (state == BUS);
  assign ack_o = (state == ACK);
  assign busy_o = (state != IDLE);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = (state == IDLE) ? (req ? BUS : IDLE) :
               (state == BUS) ? (done ? ACK : BUS) : IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      wbm_adr_o <= '0;
      wbm_sel_o <= '0;
      wbm_we_o <= 1'b0;
      wbm_dat_o <= '0;
      dat_o <= '0;
      err_o <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        wbm_adr_o <= {addr_i, 2'b00};
        wbm_sel_o <= sel_i;
        wbm_we_o <= wr;
        wbm_dat_o <= wr ? dat_i : '0;
      end
      if (state == BUS && done && !wbm_we_o) dat_o <= fail ? ERR_DATA : wbm_dat_i;
      if (state == BUS && fail) err_o <= 1'b1;
      else if (err_clr_i) err_o <= 1'b0;
    end
endmodule

// File: doc/gfx_wbm_readwrite.md
Name: gfx_wbm_readwrite

Overview:
- Single Wishbone B3 classic master that executes the single-word read/write requests issued by the GFX read/write arbiter.
- Sits directly downstream of the arbiter and directly upstream of the system memory bus.
- Latches each request's address, select, write-enable and data at cycle start, then runs exactly one Wishbone cycle.
- Returns one registered ack pulse, with read data for reads.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles allowed before abort. Used only with GFX_WBM_TIMEOUT_EN; range 1..65535.
- ERR_DATA, 32'h0000_0000: value returned on dat_o when a read ends in err_i or timeout.

Ports:
- clk_i  input  1  core clock
- rst_n_i  input  1  asynchronous active-low reset
- read_request_i  input  1  read request from arbiter
- write_request_i  input  1  write request from arbiter
- addr_i  input  [31:2]  word address
- we_i  input  1  write enable qualifier from arbiter
- sel_i  input  [3:0]  byte select
- dat_i  input  [31:0]  write data from arbiter
- dat_o  output  [31:0]  read data to arbiter
- ack_o  output  1  one-cycle completion pulse to arbiter
- busy_o  output  1  high whenever state is not IDLE
- err_o  output  1  sticky error flag, cleared by err_clr_i
- err_clr_i  input  1  clears err_o
- wbm_cyc_o  output  1  Wishbone cycle
- wbm_stb_o  output  1  Wishbone strobe
- wbm_we_o  output  1  Wishbone write enable
- wbm_adr_o  output  [31:0]  byte address; bits [1:0] are always 0
- wbm_sel_o  output  [3:0]  byte select
- wbm_dat_o  output  [31:0]  write data
- wbm_dat_i  input  [31:0]  read data
- wbm_ack_i  input  1  slave acknowledge
- wbm_err_i  input  1  slave error

Behaviour:
- Reset: all outputs 0, state IDLE. Reset asserted mid-cycle drops wbm_cyc_o/wbm_stb_o immediately (asynchronous). No ack_o is produced for the aborted request.
- Clock/reset: single clock clk_i; reset rst_n_i is asynchronous, active-low.
- States: IDLE, BUS, ACK.
- IDLE:
  - On read_request_i | write_request_i, register the following and go to BUS the next cycle:
    - wbm_adr_o = {addr_i, 2'b00}
    - wbm_sel_o = sel_i
    - wbm_we_o = write_request_i & we_i
    - wbm_dat_o = dat_i when writing, else 0
  - If both requests are high, write wins.
  - Request inputs are sampled only in IDLE.
- BUS:
  - wbm_cyc_o = wbm_stb_o = 1.
  - Latched outputs are held constant; arbiter inputs are ignored.
  - On wbm_ack_i: drop cyc/stb on the next edge, register dat_o = wbm_dat_i (reads only; writes leave dat_o unchanged), go to ACK.
  - On wbm_err_i (priority over ack if both high): same exit, dat_o = ERR_DATA for reads, set err_o.
- ACK:
  - ack_o = 1 for exactly this one cycle; then return to IDLE.
  - The requester deasserts its request in response, so IDLE never re-issues a completed request. Minimum spacing between two cycles is 1 idle cycle.
- Latency: request sampled at edge N, cyc/stb high from N+1, slave ack at edge M, ack_o high during M+1..M+2 (one cycle).
- Zero-wait-state slave: 3 cycles from request to ack_o, inclusive.
- err_o: sticky. If err_clr_i and a new error occur in the same cycle, the set wins.
- busy_o = (state != IDLE).

Optional Feature:
- Macro GFX_WBM_TIMEOUT_EN.
- When defined:
  - A 16-bit counter is cleared on entry to BUS and increments each BUS cycle.
  - Reaching TIMEOUT_CYCLES with no ack/err aborts the cycle exactly like wbm_err_i: cyc/stb drop, dat_o = ERR_DATA for reads, err_o set, ack_o pulses.
  - Ack arriving in the same cycle as the timeout is treated as a normal ack.
- When undefined: no counter; BUS waits indefinitely.

Test Plan:
- Read, zero-wait slave: read_request_i=1, addr_i=30'h0000_0400, sel_i=4'hF, slave returns 32'hCAFE_F00D → wbm_adr_o=32'h0000_1000, wbm_we_o=0, cyc high 1 cycle, ack_o single pulse 3 cycles after request, dat_o=32'hCAFE_F00D.
- Write, 3 wait states: write_request_i=1, we_i=1, sel_i=4'b0011, dat_i=32'h1234_5678 → wbm_we_o=1, wbm_dat_o/wbm_sel_o stable for 4 cycles, one ack_o, dat_o unchanged.
- Simultaneous requests, plus addr_i changed during BUS: write issued; wbm_adr_o stays at the value latched at start.
- Slave err on read → dat_o=32'h0, err_o=1 and stays 1 until err_clr_i; err_clr_i in the same cycle as a new error leaves err_o=1.
- rst_n_i low mid-BUS → cyc/stb/outputs 0 asynchronously, no ack_o; after release, the next request completes normally.
- With GFX_WBM_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks → cyc drops after 8 BUS cycles, ack_o pulses once, err_o=1.
